// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: game modes, RGB colour words and FSM states.
package led_seq_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_PLAY  = 2'd1;
  localparam logic [1:0] MODE_OVER  = 2'd2;
  localparam logic [1:0] MODE_PAUSE = 2'd3;

  localparam logic [2:0] RGB_OFF    = 3'b000;
  localparam logic [2:0] RGB_BLUE   = 3'b001;
  localparam logic [2:0] RGB_GREEN  = 3'b010;
  localparam logic [2:0] RGB_RED    = 3'b100;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_WHITE  = 3'b111;

  typedef enum logic [1:0] {
    ST_BASE  = 2'd0,
    ST_SCORE = 2'd1,
    ST_CRASH = 2'd2
  } seq_state_t;

  function automatic logic [2:0] mode_colour(input logic [1:0] mode);
    logic [2:0] c;
    case (mode)
      MODE_IDLE:  c = RGB_BLUE;
      MODE_PLAY:  c = RGB_GREEN;
      MODE_OVER:  c = RGB_RED;
      default:    c = RGB_YELLOW;
    endcase
    return c;
  endfunction

  function automatic logic mode_blinks(input logic [1:0] mode);
    return (mode == MODE_IDLE) || (mode == MODE_PAUSE);
  endfunction

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Effect time-base prescaler: one-cycle tick every DIV clocks, restartable with clr.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// RGB status-LED sequencer: base colours per game mode plus score/crash flash effects.
// Optional PWM dimming with a brightness input when LED_PWM_EN is defined.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int FLASH_TICKS  = 200,
  parameter int BLINK_TICKS  = 250,
  parameter int CRASH_BLINKS = 3
`ifdef LED_PWM_EN
  ,
  parameter int PWM_BITS     = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] game_mode,
  input  logic       score_evt,
  input  logic       crash_evt,
`ifdef LED_PWM_EN
  input  logic [PWM_BITS-1:0] brightness,
`endif
  output logic [2:0] rgb_state,
  output logic       busy
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PHASES  = 2 * CRASH_BLINKS;
  localparam int FLASH_W = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int PHASE_W = $clog2(PHASES);

  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASES - 1);

  seq_state_t         state_q, state_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [2:0]         rgb_q, rgb_d;
  logic               busy_q, busy_d;
  logic               tick;
  logic               evt_accept;
  logic [2:0]         colour;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
`endif

  // A dropped score (during crash) must not restart the time base.
  assign evt_accept = crash_evt || (score_evt && (state_q != ST_CRASH));

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (evt_accept),
    .tick  (tick)
  );

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    phase_d     = phase_q;
    if (crash_evt) begin
      state_d     = ST_CRASH;
      flash_cnt_d = '0;
      phase_d     = '0;
    end else if (score_evt && (state_q != ST_CRASH)) begin
      state_d     = ST_SCORE;
      flash_cnt_d = '0;
      phase_d     = '0;
    end else if (tick && (state_q != ST_BASE)) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d = '0;
        if ((state_q == ST_SCORE) || (phase_q == PHASE_LAST)) begin
          state_d = ST_BASE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
      end
    end
  end

  // Outputs are computed from the next state so they register on the same edge.
  always_comb begin
    case (state_d)
      ST_SCORE: colour = RGB_WHITE;
      ST_CRASH: colour = phase_d[0] ? RGB_OFF : RGB_RED;
      default: begin
        colour = mode_colour(game_mode);
        if (mode_blinks(game_mode)) begin
          colour = colour & {3{blink_ph_q}};
        end
      end
    endcase
    busy_d = (state_d != ST_BASE);
`ifdef LED_PWM_EN
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    rgb_d     = colour & {3{pwm_cnt_q < brightness}};
`else
    rgb_d     = colour;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_BASE;
      flash_cnt_q <= '0;
      phase_q     <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      rgb_q       <= RGB_OFF;
      busy_q      <= 1'b0;
`ifdef LED_PWM_EN
      pwm_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      flash_cnt_q <= flash_cnt_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      rgb_q       <= rgb_d;
      busy_q      <= busy_d;
`ifdef LED_PWM_EN
      pwm_cnt_q   <= pwm_cnt_d;
`endif
    end
  end

  assign rgb_state = rgb_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed testbench for led_sequencer with DIV=10, FLASH_TICKS=3, BLINK_TICKS=2, CRASH_BLINKS=3.
`timescale 1ns/1ps
module tb_led_sequencer;

  localparam logic [2:0] C_OFF = 3'b000;
  localparam logic [2:0] C_BLU = 3'b001;
  localparam logic [2:0] C_GRN = 3'b010;
  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_YEL = 3'b110;
  localparam logic [2:0] C_WHT = 3'b111;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_PLAY  = 2'd1;
  localparam logic [1:0] M_OVER  = 2'd2;
  localparam logic [1:0] M_PAUSE = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] game_mode = 2'd0;
  logic       score_evt = 1'b0;
  logic       crash_evt = 1'b0;
  logic [2:0] rgb_state;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_sequencer #(
    .CLK_HZ       (1000),
    .TICK_HZ      (100),
    .FLASH_TICKS  (3),
    .BLINK_TICKS  (2),
    .CRASH_BLINKS (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .game_mode (game_mode),
    .score_evt (score_evt),
    .crash_evt (crash_evt),
`ifdef LED_PWM_EN
    .brightness('1),
`endif
    .rgb_state (rgb_state),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check outputs now, then advance one clock; repeated n times.
  task automatic hold(input string tag, input int n, input logic [2:0] rgb, input logic bsy);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].rgb", tag, i), 32'(rgb_state), 32'(rgb));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(bsy));
      step();
    end
  endtask

  task automatic do_reset(input string tag, input logic [1:0] mode);
    rst_n     = 1'b0;
    game_mode = mode;
    score_evt = 1'b0;
    crash_evt = 1'b0;
    step();
    step();
    chk({tag, ".rst_rgb"}, 32'(rgb_state), 32'(C_OFF));
    chk({tag, ".rst_busy"}, 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic crash_phases(input string tag, input int first);
    for (int p = first; p < 6; p++) begin
      hold($sformatf("%s.ph%0d", tag, p), 30, (p % 2 == 0) ? C_RED : C_OFF, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Reset value, first base colour, steady PLAY, mode latency
    do_reset("s1", M_PLAY);
    hold("s1.play", 20, C_GRN, 1'b0);
    game_mode = M_OVER;
    step();
    hold("s1.over", 3, C_RED, 1'b0);

    // Blinking base colours
    do_reset("s2i", M_IDLE);
    hold("s2.idle_on", 20, C_BLU, 1'b0);
    hold("s2.idle_off", 20, C_OFF, 1'b0);
    hold("s2.idle_on2", 20, C_BLU, 1'b0);
    do_reset("s2p", M_PAUSE);
    hold("s2.pause_on", 20, C_YEL, 1'b0);
    hold("s2.pause_off", 20, C_OFF, 1'b0);
    hold("s2.pause_on2", 20, C_YEL, 1'b0);

    // Score flash and retrigger
    do_reset("s3", M_PLAY);
    hold("s3.pre", 7, C_GRN, 1'b0);
    score_evt = 1'b1; step(); score_evt = 1'b0;
    hold("s3.flash", 30, C_WHT, 1'b1);
    hold("s3.after", 5, C_GRN, 1'b0);
    score_evt = 1'b1; step(); score_evt = 1'b0;
    hold("s3.flash2a", 15, C_WHT, 1'b1);
    score_evt = 1'b1; step(); score_evt = 1'b0;
    hold("s3.flash2b", 30, C_WHT, 1'b1);
    hold("s3.after2", 5, C_GRN, 1'b0);

    // Crash sequence with a mode change mid-effect
    do_reset("s4", M_PLAY);
    hold("s4.pre", 7, C_GRN, 1'b0);
    crash_evt = 1'b1; step(); crash_evt = 1'b0;
    hold("s4.ph0", 30, C_RED, 1'b1);
    hold("s4.ph1", 30, C_OFF, 1'b1);
    game_mode = M_OVER;
    crash_phases("s4", 2);
    hold("s4.after", 10, C_RED, 1'b0);

    // Arbitration
    do_reset("s5", M_PLAY);
    hold("s5.pre", 3, C_GRN, 1'b0);
    score_evt = 1'b1; crash_evt = 1'b1; step();
    score_evt = 1'b0; crash_evt = 1'b0;
    hold("s5.ph0", 30, C_RED, 1'b1);
    hold("s5.ph1a", 10, C_OFF, 1'b1);
    score_evt = 1'b1;
    hold("s5.ph1b", 1, C_OFF, 1'b1);
    score_evt = 1'b0;
    hold("s5.ph1c", 19, C_OFF, 1'b1);
    crash_phases("s5", 2);
    hold("s5.after", 5, C_GRN, 1'b0);
    score_evt = 1'b1; step(); score_evt = 1'b0;
    hold("s5.score", 10, C_WHT, 1'b1);
    crash_evt = 1'b1; step(); crash_evt = 1'b0;
    crash_phases("s5b", 0);
    hold("s5b.after", 5, C_GRN, 1'b0);

    // Reset in the middle of a crash
    do_reset("s6", M_PLAY);
    hold("s6.pre", 5, C_GRN, 1'b0);
    crash_evt = 1'b1; step(); crash_evt = 1'b0;
    hold("s6.ph0", 30, C_RED, 1'b1);
    hold("s6.ph1", 20, C_OFF, 1'b1);
    rst_n = 1'b0;
    step();
    chk("s6.abort_rgb", 32'(rgb_state), 32'(C_OFF));
    chk("s6.abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    hold("s6.after", 10, C_GRN, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
